adder_result_stage: RTL and testbench
=====================================

ADDER_RESULT_STAGE -- requirements
Module: adder_result_stage

Interface
REQ-001 Parameter WIDTH, default 32, sum width; matches adder operand width.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
REQ-004 in_valid  input  1  upstream adder result valid.
REQ-005 in_ready  output  1  stage can accept a result this cycle.
REQ-006 in_sum  input  WIDTH  adder sum S.
REQ-007 in_cout  input  1  adder carry-out.
REQ-008 in_ovf  input  1  adder signed overflow.
REQ-009 out_valid  output  1  head entry valid.
REQ-010 out_ready  input  1  downstream accepts head entry.
REQ-011 out_sum  output  WIDTH  head entry sum.
REQ-012 out_flags  output  4  head entry flags {N,Z,C,V}, bit 3 = N.
REQ-013 ovf_sticky  output  1  sticky overflow (only with STICKY_OVF_EN).
REQ-014 sticky_clr  input  1  clears ovf_sticky (ignored without STICKY_OVF_EN).

Function
REQ-015 The stage SHALL be a 2-entry FIFO (skid buffer) of {sum, flags} with 1-bit write pointer, 1-bit read pointer, 2-bit count.
REQ-016 Push SHALL occur iff in_valid && in_ready; pop SHALL occur iff out_valid && out_ready.
REQ-017 in_ready SHALL equal (count != 2), driven from registered count only, no combinational path from out_ready.
REQ-018 out_valid SHALL equal (count != 0); out_sum/out_flags SHALL show the read-pointer entry, held stable while out_valid && !out_ready.
REQ-019 Flags SHALL be computed at push: N = in_sum[WIDTH-1], Z = (in_sum == 0), C = in_cout, V = in_ovf.
REQ-020 Latency SHALL be 1 cycle: push in cycle n gives out_valid in cycle n+1 when previously empty.
REQ-021 Push and pop in the same cycle with count 1 SHALL leave count 1, both pointers advancing; order preserved.
REQ-022 Count 2: no push (in_ready 0); pop SHALL make in_ready 1 next cycle.
REQ-023 Count 0: no pop possible; out_sum/out_flags content is don't-care for checking but SHALL be deterministic (last written or reset value).
REQ-024 Pointers SHALL wrap 1 -> 0 without extra logic.
REQ-025 Protocol rule for upstream: in_valid and data held until push; stage does not check.

Reset
REQ-026 On rst_n low, asynchronously: count 0, pointers 0, storage 0, out_valid 0, in_ready 1 after release, ovf_sticky 0.
REQ-027 Reset mid-operation SHALL discard all buffered entries; no partial pop visible after release.

Configuration
REQ-028 Macro ADDER_RESULT_STICKY_OVF_EN defined: ovf_sticky SHALL set on the cycle after a pop whose V = 1, clear the cycle after sticky_clr = 1; simultaneous pop-with-V and sticky_clr SHALL leave it set.
REQ-029 Macro undefined: ovf_sticky SHALL be tied 0, no sticky flop synthesised, sticky_clr unused.

Structure
REQ-030 Shared package adder_pkg SHALL hold WIDTH default, flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0), and result-entry struct {sum, flags}.
REQ-031 One sub-module natural: adder_flags (combinational N/Z/C/V from sum, cout, ovf); FIFO storage inline.

Verification
REQ-032 Single push in_sum=0x00000000, cout=1, ovf=0, out_ready=1 -> cycle+1 out_valid=1, out_flags=4'b0110, then empty.
REQ-033 out_ready=0, push 0x80000000/ovf=1 then 0x00000001 -> after 2 pushes in_ready=0, third in_valid ignored; release out_ready -> outputs 0x80000000 flags 4'b1001, then 0x00000001 flags 4'b0000.
REQ-034 Continuous in_valid=1, out_ready=1, 100 incrementing sums -> one output per cycle after 1-cycle latency, order and values intact, in_ready never 0.
REQ-035 Random in_valid/out_ready, 10k transfers -> scoreboard matches, count never exceeds 2, out_sum stable while stalled.
REQ-036 STICKY_OVF_EN: pop entry with V=1 -> ovf_sticky=1 next cycle; sticky_clr same cycle as another V=1 pop -> remains 1; sticky_clr alone -> 0.
REQ-037 Assert rst_n low with 2 entries buffered -> out_valid=0 immediately, in_ready=1 after release, ovf_sticky=0.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the adder result stage: default width, flag bit positions
// and the {sum, flags} result entry.
package adder_pkg;

    localparam int ADDER_WIDTH = 32;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic [ADDER_WIDTH-1:0] sum;
        logic [3:0]             flags;
    } result_entry_t;

endpackage

// File: rtl/adder_flags.sv
// Combinational N/Z/C/V flag generation for one adder result.
module adder_flags
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic [WIDTH-1:0] i_sum,
    input  logic             i_cout,
    input  logic             i_ovf,
    output logic [3:0]       o_flags
);

    always_comb begin
        o_flags         = '0;
        o_flags[FLAG_N] = i_sum[WIDTH-1];
        o_flags[FLAG_Z] = (i_sum == '0);
        o_flags[FLAG_C] = i_cout;
        o_flags[FLAG_V] = i_ovf;
    end

endmodule

// File: rtl/adder_result_stage.sv
// Two-entry skid FIFO holding {sum, flags} between the adder and its consumer.
// Optional sticky overflow flag is enabled by defining ADDER_RESULT_STICKY_OVF_EN.
module adder_result_stage
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_cout,
    input  logic             in_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [3:0]       out_flags,
    output logic             ovf_sticky,
    input  logic             sticky_clr
);

    logic [WIDTH-1:0] r_sum   [2];
    logic [3:0]       r_flags [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;

    logic [3:0]       w_flags;
    logic             w_push;
    logic             w_pop;

    adder_flags #(.WIDTH(WIDTH)) u_flags (
        .i_sum   (in_sum),
        .i_cout  (in_cout),
        .i_ovf   (in_ovf),
        .o_flags (w_flags)
    );

    // Ready comes only from the registered count, so out_ready never reaches in_ready.
    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign out_sum   = r_sum[r_rptr];
    assign out_flags = r_flags[r_rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_sum[i]   <= '0;
                r_flags[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_sum[r_wptr]   <= in_sum;
                r_flags[r_wptr] <= w_flags;
                r_wptr          <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef ADDER_RESULT_STICKY_OVF_EN
    logic r_ovf_sticky;

    // A popped overflow wins over a same-cycle clear so no event is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_sticky <= 1'b0;
        end else if (w_pop && r_flags[r_rptr][FLAG_V]) begin
            r_ovf_sticky <= 1'b1;
        end else if (sticky_clr) begin
            r_ovf_sticky <= 1'b0;
        end
    end

    assign ovf_sticky = r_ovf_sticky;
`else
    logic w_unused_sticky_clr;

    assign w_unused_sticky_clr = sticky_clr;
    assign ovf_sticky          = 1'b0;
`endif

endmodule

// File: tb/tb_adder_result_stage.sv
// Scoreboard bench for adder_result_stage: directed vectors with hand-computed flags.
module tb_adder_result_stage;
    import adder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_sum = '0;
    logic        in_cout = 1'b0;
    logic        in_ovf = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_sum;
    logic [3:0]  out_flags;
    logic        ovf_sticky;
    logic        sticky_clr = 1'b0;

    int errors = 0;
    int checks = 0;
    int n_pops = 0;

    result_entry_t sb[$];

    adder_result_stage #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_cout    (in_cout),
        .in_ovf     (in_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_flags  (out_flags),
        .ovf_sticky (ovf_sticky),
        .sticky_clr (sticky_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds in_valid until the stage accepts; expected entry is queued for the handshake edge.
    task automatic push(input logic [31:0] s, input logic c, input logic v, input logic [3:0] f);
        bit done = 0;
        in_valid = 1'b1;
        in_sum   = s;
        in_cout  = c;
        in_ovf   = v;
        for (int n = 0; n < 50 && !done; n++) begin
            if (in_ready) begin
                sb.push_back('{sum: s, flags: f});
                done = 1;
            end
            tick();
        end
        in_valid = 1'b0;
        if (!done) chk("push_timeout", 64'd0, 64'd1);
    endtask

    // Monitor: compares every pop against the scoreboard and checks stall stability.
    logic        stall_prev = 1'b0;
    logic [31:0] stall_sum;
    logic [3:0]  stall_flags;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && out_valid) begin
                chk("stall_sum", {32'd0, out_sum}, {32'd0, stall_sum});
                chk("stall_flags", {60'd0, out_flags}, {60'd0, stall_flags});
            end
            if (out_valid && out_ready) begin
                n_pops++;
                if (sb.size() == 0) begin
                    chk("pop_unexpected", 64'd1, 64'd0);
                end else begin
                    result_entry_t e;
                    e = sb.pop_front();
                    chk("out_sum", {32'd0, out_sum}, {32'd0, e.sum});
                    chk("out_flags", {60'd0, out_flags}, {60'd0, e.flags});
                end
            end
            stall_prev  = out_valid && !out_ready;
            stall_sum   = out_sum;
            stall_flags = out_flags;
        end
    end

    logic [31:0] vsum  [4];
    logic        vcout [4];
    logic        vovf  [4];
    logic [3:0]  vflg  [4];

    initial begin
        int pops0;
        int xfers;
        bit acc;

        vsum[0] = 32'h7fffffff; vcout[0] = 1'b0; vovf[0] = 1'b1; vflg[0] = 4'b0001;
        vsum[1] = 32'hffffffff; vcout[1] = 1'b1; vovf[1] = 1'b0; vflg[1] = 4'b1010;
        vsum[2] = 32'h00000000; vcout[2] = 1'b1; vovf[2] = 1'b1; vflg[2] = 4'b0111;
        vsum[3] = 32'h12345678; vcout[3] = 1'b0; vovf[3] = 1'b0; vflg[3] = 4'b0000;

        #2;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_sticky", {63'd0, ovf_sticky}, 64'd0);
        #10 rst_n = 1'b1;
        tick();
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_sum", {32'd0, out_sum}, 64'd0);

        // Single push of zero with carry: Z and C set, one-cycle latency.
        out_ready = 1'b1;
        push(32'h0, 1'b1, 1'b0, 4'b0110);
        chk("lat_out_valid", {63'd0, out_valid}, 64'd1);
        chk("lat_flags", {60'd0, out_flags}, 64'h6);
        tick();
        chk("empty_after", {63'd0, out_valid}, 64'd0);

        // Fill while stalled; third request must be refused.
        out_ready = 1'b0;
        push(32'h80000000, 1'b0, 1'b1, 4'b1001);
        push(32'h00000001, 1'b0, 1'b0, 4'b0000);
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        in_valid = 1'b1;
        in_sum   = 32'hdeadbeef;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full_hold_ready", {63'd0, in_ready}, 64'd0);
        end
        chk("full_head", {32'd0, out_sum}, 64'h80000000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("ready_after_pop", {63'd0, in_ready}, 64'd1);
        tick();
        chk("drained", {63'd0, out_valid}, 64'd0);

        // Back-to-back streaming: one result per cycle, never back-pressured.
        pops0    = n_pops;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_sum  = i;
            in_cout = i[0];
            in_ovf  = 1'b0;
            chk("stream_ready", {63'd0, in_ready}, 64'd1);
            sb.push_back('{sum: i, flags: {1'b0, (i == 0), i[0], 1'b0}});
            tick();
            chk("stream_valid", {63'd0, out_valid}, 64'd1);
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("stream_pops", n_pops - pops0, 64'd100);

        // Random handshake with the directed vector table.
        xfers = 0;
        for (int cyc = 0; cyc < 4000 && xfers < 400; cyc++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (!in_valid && $urandom_range(0, 1) == 1) begin
                in_sum   = vsum[xfers % 4];
                in_cout  = vcout[xfers % 4];
                in_ovf   = vovf[xfers % 4];
                in_valid = 1'b1;
            end
            acc = 0;
            if (in_valid && in_ready) begin
                sb.push_back('{sum: vsum[xfers % 4], flags: vflg[xfers % 4]});
                xfers++;
                acc = 1;
            end
            tick();
            if (acc) in_valid = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        chk("rand_drained", sb.size(), 64'd0);
        chk("rand_xfers", xfers, 64'd400);

`ifdef ADDER_RESULT_STICKY_OVF_EN
        out_ready = 1'b1;
        push(32'h0, 1'b0, 1'b1, 4'b0101);
        tick();
        chk("sticky_set", {63'd0, ovf_sticky}, 64'd1);
        out_ready = 1'b0;
        push(32'h5, 1'b0, 1'b1, 4'b0001);
        sticky_clr = 1'b1;
        out_ready  = 1'b1;
        tick();
        sticky_clr = 1'b0;
        chk("sticky_clr_vs_pop", {63'd0, ovf_sticky}, 64'd1);
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        chk("sticky_cleared", {63'd0, ovf_sticky}, 64'd0);
        out_ready = 1'b1;
        push(32'h0, 1'b0, 1'b1, 4'b0101);
        tick();
`endif

        // Reset with two entries buffered discards them.
        out_ready = 1'b0;
        push(32'hcafef00d, 1'b0, 1'b1, 4'b1001);
        push(32'h00000002, 1'b1, 1'b0, 4'b0010);
        chk("pre_rst_full", {63'd0, in_ready}, 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_sticky", {63'd0, ovf_sticky}, 64'd0);
        sb.delete();
        out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", {63'd0, in_ready}, 64'd1);
        chk("post_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("post_rst_sticky", {63'd0, ovf_sticky}, 64'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
